// File: rtl/ctrl_xfer_seq_if.sv
// Endpoint-0 control-transfer sequencer bus: SETUP intake, decoder handshake,
// data/status stage requests and transfer status.
interface ctrl_xfer_seq_if;
  logic        setup_valid;
  logic [63:0] setup_data;
  logic        setup_ready;
  logic        dec_enable;
  logic [63:0] dec_data;
  logic        dec_busy;
  logic        dec_stall;
  logic        pkt_req;
  logic [6:0]  pkt_len;
  logic        pkt_dir;
  logic        pkt_ack;
  logic        status_req;
  logic        status_dir;
  logic        status_ack;
  logic        done;
  logic        stall;
  logic        abort;
  logic [15:0] rem_bytes;
  logic [2:0]  state;

  // master: packet engine / decoder side driving the sequencer
  modport master (
    output setup_valid, setup_data, dec_busy, dec_stall, pkt_ack, status_ack,
    input  setup_ready, dec_enable, dec_data, pkt_req, pkt_len, pkt_dir,
    input  status_req, status_dir, done, stall, abort, rem_bytes, state
  );

  modport slave (
    input  setup_valid, setup_data, dec_busy, dec_stall, pkt_ack, status_ack,
    output setup_ready, dec_enable, dec_data, pkt_req, pkt_len, pkt_dir,
    output status_req, status_dir, done, stall, abort, rem_bytes, state
  );
endinterface

// File: rtl/ctrl_xfer_seq.sv
// Sequences one USB control transfer: SETUP latch, decoder handshake with timeout,
// DATA stage split into MAX_PKT packets, STATUS stage, stall and abort handling.
module ctrl_xfer_seq #(
  parameter int unsigned MAX_PKT = 8,
  parameter int unsigned TIMEOUT = 256
) (
  input logic            clk,
  input logic            rst,
  ctrl_xfer_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StData   = 3'd2,
    StStatus = 3'd3,
    StDone   = 3'd4,
    StStall  = 3'd5
  } state_e;

  localparam int unsigned    CntW     = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [15:0]    MaxPkt16 = 16'(MAX_PKT);
  localparam logic [6:0]     MaxPkt7  = 7'(MAX_PKT);

  state_e          state_q, state_d;
  logic [63:0]     data_q, data_d;
  logic [15:0]     rem_q, rem_d;
  logic            dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      len_q, len_d;
  logic            dec_enable_q, dec_enable_d;
  logic            abort_q, abort_d;
  logic            pkt_req_q, pkt_req_d;
  logic            status_req_q, status_req_d;
  logic            status_dir_q, status_dir_d;
  logic            done_q, done_d;
  logic            stall_q, stall_d;
  logic            accept;

  function automatic logic [6:0] clamp_len(input logic [15:0] r);
    return (r > MaxPkt16) ? MaxPkt7 : r[6:0];
  endfunction

  // setup_ready is permanently high, so any valid SETUP is accepted
  assign accept = bus.setup_valid;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    if (accept) begin
      state_d = StDecode;
      data_d  = bus.setup_data;
      rem_d   = bus.setup_data[15:0];
      dir_d   = bus.setup_data[63];
      cnt_d   = '0;
    end else begin
      case (state_q)
        StDecode: begin
          cnt_d = cnt_q + CntW'(1);
          // The first DECODE cycle is the enable pulse; the decoder is not sampled yet.
          if (cnt_q != '0 && !bus.dec_busy) begin
            if (bus.dec_stall) begin
              state_d = StStall;
            end else if (rem_q == 16'd0) begin
              state_d = StStatus;
            end else begin
              state_d = StData;
              len_d   = clamp_len(rem_q);
            end
          end else if (cnt_q == CntLast) begin
            state_d = StStall;
          end
        end
        StData: begin
          if (bus.pkt_ack) begin
            rem_d = rem_q - {9'd0, len_q};
            // A short packet or an exact finish ends the stage; no trailing ZLP.
            if (rem_d == 16'd0 || len_q < MaxPkt7) begin
              state_d = StStatus;
            end else begin
              len_d = clamp_len(rem_d);
            end
          end
        end
        StStatus: begin
          if (bus.status_ack) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_comb begin
    dec_enable_d = accept;
    abort_d      = accept && (state_q == StDecode || state_q == StData || state_q == StStatus);
    pkt_req_d    = (state_d == StData);
    status_req_d = (state_d == StStatus);
    // Zero-length transfers always finish with an IN status stage.
    status_dir_d = (state_d == StStatus) && ((data_d[15:0] == 16'd0) || !dir_d);
    done_d       = (state_d == StDone);
    stall_d      = (state_d == StStall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      data_q       <= '0;
      rem_q        <= '0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      dec_enable_q <= 1'b0;
      abort_q      <= 1'b0;
      pkt_req_q    <= 1'b0;
      status_req_q <= 1'b0;
      status_dir_q <= 1'b0;
      done_q       <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      dec_enable_q <= dec_enable_d;
      abort_q      <= abort_d;
      pkt_req_q    <= pkt_req_d;
      status_req_q <= status_req_d;
      status_dir_q <= status_dir_d;
      done_q       <= done_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.setup_ready = 1'b1;
  assign bus.dec_enable  = dec_enable_q;
  assign bus.dec_data    = data_q;
  assign bus.pkt_req     = pkt_req_q;
  assign bus.pkt_len     = len_q;
  assign bus.pkt_dir     = dir_q;
  assign bus.status_req  = status_req_q;
  assign bus.status_dir  = status_dir_q;
  assign bus.done        = done_q;
  assign bus.stall       = stall_q;
  assign bus.abort       = abort_q;
  assign bus.rem_bytes   = rem_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_ctrl_xfer_seq.sv
// Bench for ctrl_xfer_seq: transaction-level reference model compared every cycle,
// directed control transfers with literal expectations, then randomized traffic.
module tb_ctrl_xfer_seq;
  localparam int MaxPkt  = 8;
  localparam int Timeout = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_xfer_seq_if bus ();

  ctrl_xfer_seq #(
    .MAX_PKT(MaxPkt),
    .TIMEOUT(Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase of the transfer plus bytes still owed.
  // Phases: 0 idle, 1 decode, 2 data, 3 status, 4 done, 5 stall.
  int          m_phase  = 0;
  int          m_rem    = 0;
  logic        m_in     = 1'b0;
  logic [63:0] m_setup  = '0;
  int          m_dwell  = 0;
  logic        m_abort  = 1'b0;
  logic        m_enable = 1'b0;

  function automatic int chunk_of(input int r);
    return (r < MaxPkt) ? r : MaxPkt;
  endfunction

  task automatic model_step();
    int n;
    if (!rst) begin
      m_phase = 0; m_rem = 0; m_in = 1'b0; m_setup = '0; m_dwell = 0;
      m_abort = 1'b0; m_enable = 1'b0;
      return;
    end
    m_abort  = 1'b0;
    m_enable = 1'b0;
    if (bus.setup_valid) begin
      m_abort  = (m_phase >= 1 && m_phase <= 3);
      m_enable = 1'b1;
      m_setup  = bus.setup_data;
      m_rem    = int'(bus.setup_data[15:0]);
      m_in     = bus.setup_data[63];
      m_phase  = 1;
      m_dwell  = 0;
      return;
    end
    case (m_phase)
      1: begin
        m_dwell++;
        if (m_dwell >= 2 && !bus.dec_busy) m_phase = bus.dec_stall ? 5 : ((m_rem == 0) ? 3 : 2);
        else if (m_dwell == Timeout) m_phase = 5;
      end
      2: if (bus.pkt_ack) begin
        n = chunk_of(m_rem);
        m_rem -= n;
        if (m_rem == 0 || n < MaxPkt) m_phase = 3;
      end
      3: if (bus.status_ack) m_phase = 4;
      4: m_phase = 0;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    model_step();
    #2;
    chk("state", bus.state, m_phase);
    chk("setup_ready", bus.setup_ready, 1);
    chk("dec_enable", bus.dec_enable, m_enable);
    chk("abort", bus.abort, m_abort);
    chk("done", bus.done, m_phase == 4);
    chk("stall", bus.stall, m_phase == 5);
    chk("pkt_req", bus.pkt_req, m_phase == 2);
    chk("status_req", bus.status_req, m_phase == 3);
    chk("rem_bytes", bus.rem_bytes, m_rem);
    chk("dec_data", bus.dec_data, m_setup);
    if (m_phase == 2) begin
      chk("pkt_len", bus.pkt_len, chunk_of(m_rem));
      chk("pkt_dir", bus.pkt_dir, m_in);
    end
    if (m_phase == 3) chk("status_dir", bus.status_dir, (m_setup[15:0] == 16'd0) ? 1'b1 : !m_in);
  end

  // Results of the last serviced transfer
  int s_npkt, s_pdir, s_sdir, s_ndone, s_stall_at, s_fin;
  int s_lens[16];

  task automatic serve(input int busy_cyc);
    s_npkt = 0; s_pdir = -1; s_sdir = -1; s_ndone = 0; s_stall_at = -1; s_fin = 0;
    foreach (s_lens[i]) s_lens[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bus.setup_valid = 1'b0;
      bus.pkt_ack     = 1'b0;
      bus.status_ack  = 1'b0;
      bus.dec_busy    = (c < busy_cyc);
      if (bus.stall) begin s_stall_at = c; s_fin = 1; break; end
      if (s_ndone > 0 && !bus.done && bus.state == 3'd0) begin s_fin = 1; break; end
      if (bus.done) s_ndone++;
      if (bus.pkt_req) begin
        if (s_npkt < 16) s_lens[s_npkt] = int'(bus.pkt_len);
        s_npkt++;
        s_pdir = int'(bus.pkt_dir);
        bus.pkt_ack = 1'b1;
      end
      if (bus.status_req) begin
        s_sdir = int'(bus.status_dir);
        bus.status_ack = 1'b1;
      end
    end
  endtask

  task automatic run_xfer(input logic [63:0] d, input int busy_cyc, input logic stl);
    @(negedge clk);
    bus.setup_valid = 1'b1;
    bus.setup_data  = d;
    bus.dec_busy    = (busy_cyc > 0);
    bus.dec_stall   = stl;
    bus.pkt_ack     = 1'b0;
    bus.status_ack  = 1'b0;
    serve(busy_cyc);
  endtask

  task automatic wait_pkt_req(input string nm);
    int k;
    for (k = 0; k < 50; k++) begin
      if (bus.pkt_req) break;
      @(negedge clk);
    end
    chk(nm, bus.pkt_req, 1);
  endtask

  initial begin
    logic [63:0] rd;
    int hold;
    bus.setup_valid = 1'b0;
    bus.setup_data  = '0;
    bus.dec_busy    = 1'b0;
    bus.dec_stall   = 1'b0;
    bus.pkt_ack     = 1'b0;
    bus.status_ack  = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_ready", bus.setup_ready, 1);
    chk("rst_outs", {bus.dec_enable, bus.pkt_req, bus.status_req, bus.status_dir,
                     bus.done, bus.stall, bus.abort, bus.pkt_dir}, 0);
    chk("rst_data", bus.dec_data, 0);
    chk("rst_rem", bus.rem_bytes, 0);
    chk("rst_len", bus.pkt_len, 0);
    rst = 1'b1;

    // No-data request, decoder busy two cycles
    run_xfer(64'h2109_0000_0000_0000, 2, 1'b0);
    chk("t1_fin", s_fin, 1);
    chk("t1_npkt", s_npkt, 0);
    chk("t1_sdir", s_sdir, 1);
    chk("t1_done", s_ndone, 1);
    chk("t1_idle", bus.state, 0);

    // OUT, 20 bytes
    run_xfer(64'h2106_0000_0005_0014, 1, 1'b0);
    chk("t2_fin", s_fin, 1);
    chk("t2_npkt", s_npkt, 3);
    chk("t2_len0", s_lens[0], 8);
    chk("t2_len1", s_lens[1], 8);
    chk("t2_len2", s_lens[2], 4);
    chk("t2_pdir", s_pdir, 0);
    chk("t2_sdir", s_sdir, 1);
    chk("t2_done", s_ndone, 1);

    // IN, 16 bytes: exact multiple, no ZLP
    run_xfer(64'hA106_0000_0005_0010, 0, 1'b0);
    chk("t3_npkt", s_npkt, 2);
    chk("t3_len0", s_lens[0], 8);
    chk("t3_len1", s_lens[1], 8);
    chk("t3_pdir", s_pdir, 1);
    chk("t3_sdir", s_sdir, 0);
    chk("t3_done", s_ndone, 1);

    // Decoder hang: stall after TIMEOUT cycles in DECODE
    run_xfer(64'h8006_0100_0000_0012, 300, 1'b0);
    chk("t4_stall_at", s_stall_at, 256);
    chk("t4_done", s_ndone, 0);
    bus.dec_busy    = 1'b0;
    bus.setup_valid = 1'b1;
    bus.setup_data  = 64'h2109_0000_0000_0000;
    @(negedge clk);
    bus.setup_valid = 1'b0;
    chk("t4_clear", bus.stall, 0);
    chk("t4_enable", bus.dec_enable, 1);
    chk("t4_state", bus.state, 1);
    chk("t4_noabort", bus.abort, 0);
    repeat (3) @(negedge clk);

    // Abort: new SETUP after first data packet
    bus.setup_valid = 1'b1;
    bus.setup_data  = 64'h2106_0000_0005_0014;
    @(negedge clk);
    bus.setup_valid = 1'b0;
    wait_pkt_req("t5_req");
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
    chk("t5_rem_mid", bus.rem_bytes, 12);
    bus.setup_valid = 1'b1;
    bus.setup_data  = 64'hC006_0000_0000_0020;
    @(negedge clk);
    bus.setup_valid = 1'b0;
    chk("t5_abort", bus.abort, 1);
    chk("t5_rem", bus.rem_bytes, 32);
    chk("t5_state", bus.state, 1);
    chk("t5_enable", bus.dec_enable, 1);
    serve(0);
    chk("t5_npkt", s_npkt, 4);
    chk("t5_done", s_ndone, 1);

    // Asynchronous reset mid-DATA, then decoder stall
    bus.setup_valid = 1'b1;
    bus.setup_data  = 64'h2106_0000_0005_0014;
    @(negedge clk);
    bus.setup_valid = 1'b0;
    wait_pkt_req("t6_req");
    #2 rst = 1'b0;
    #1;
    chk("t6_state", bus.state, 0);
    chk("t6_outs", {bus.dec_enable, bus.pkt_req, bus.status_req, bus.done, bus.stall,
                    bus.abort}, 0);
    chk("t6_rem", bus.rem_bytes, 0);
    chk("t6_data", bus.dec_data, 0);
    chk("t6_len", bus.pkt_len, 0);
    @(negedge clk);
    rst = 1'b1;
    run_xfer(64'h0009_0001_0000_0000, 2, 1'b1);
    chk("t6_stall_at", s_stall_at, 3);
    chk("t6_nodone", s_ndone, 0);
    bus.dec_stall = 1'b0;

    // Randomized traffic
    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      rd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rd[15:0] = 16'd0;
        1:       rd[15:0] = 16'(8 * $urandom_range(1, 6));
        default: rd[15:0] = 16'($urandom_range(1, 70));
      endcase
      bus.setup_valid = (hold == 0) && ($urandom_range(0, 29) == 0);
      bus.setup_data  = rd;
      if (hold > 0) begin
        hold--;
        bus.dec_busy = 1'b1;
      end else begin
        bus.dec_busy = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 499) == 0) hold = 300;
      end
      bus.dec_stall  = ($urandom_range(0, 7) == 0);
      bus.pkt_ack    = $urandom_range(0, 1) == 1;
      bus.status_ack = $urandom_range(0, 1) == 1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
